// File: rtl/rx_audio_drain.sv
// rx_audio_drain: drains one ready RX audio buffer (samples plus ticks trailer)
// through the single-word memory read port onto a valid/ready stream.
module rx_audio_drain #(
  parameter int unsigned NRX_SAMPS  = 672,
  parameter int unsigned TAIL_WORDS = 3
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        rx_rd_C,
  input  logic [15:0] rx_dout_C,
  input  logic        abort,
  input  logic        out_ready,
  output logic        get_rx_srq_C,
  output logic        get_buf_ctr_C,
  output logic        get_rx_samp_C,
  output logic        reset_bufs_C,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic [15:0] buf_ctr,
  output logic        busy,
  output logic        done
);

  localparam logic [16:0] TOTAL = 17'(NRX_SAMPS + TAIL_WORDS);
  localparam logic [16:0] LAST  = TOTAL - 17'd1;

  typedef enum logic [2:0] {IDLE, SRQ, CTR, CTR_CAP, READ, DONE} state_t;

  state_t      state_q;
  logic        srq_q, ctr_q, samp_q, rb_q, done_q;
  logic        pend_q;
  logic [15:0] out_data_q, buf_ctr_q, skid_q;
  logic        out_valid_q, out_last_q, skid_v_q, skid_last_q;
  logic [16:0] word_cnt_q;

  logic        consume, issue, arr_last;
  logic [16:0] rcv_next;

  always_comb begin
    consume  = out_valid_q & out_ready;
    rcv_next = word_cnt_q + 17'(pend_q);
    arr_last = (word_cnt_q == LAST);
    issue    = (state_q == READ) & ~abort & ~samp_q & ~skid_v_q &
               (~out_valid_q | out_ready) & (rcv_next < TOTAL);
  end

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      srq_q       <= 1'b0;
      ctr_q       <= 1'b0;
      samp_q      <= 1'b0;
      rb_q        <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      skid_q      <= '0;
      skid_v_q    <= 1'b0;
      skid_last_q <= 1'b0;
      buf_ctr_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      srq_q  <= 1'b0;
      ctr_q  <= 1'b0;
      samp_q <= 1'b0;
      rb_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        rb_q        <= 1'b1;
        state_q     <= IDLE;
        pend_q      <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        skid_v_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (rx_rd_C) begin
            state_q <= SRQ;
            srq_q   <= 1'b1;
          end
          SRQ: begin
            state_q <= CTR;
            ctr_q   <= 1'b1;
          end
          CTR: state_q <= CTR_CAP;
          CTR_CAP: begin
            buf_ctr_q  <= rx_dout_C;
            word_cnt_q <= '0;
            state_q    <= READ;
          end
          READ: begin
            samp_q <= issue;
            pend_q <= samp_q;
            // The read issued on a load edge can land while the sink stalls;
            // the skid word keeps that case lossless at one word per 2 cycles.
            if (skid_v_q) begin
              if (consume) begin
                out_data_q <= skid_q;
                out_last_q <= skid_last_q;
                skid_v_q   <= 1'b0;
              end
            end else if (pend_q) begin
              word_cnt_q <= word_cnt_q + 17'd1;
              if (~out_valid_q | consume) begin
                out_data_q  <= rx_dout_C;
                out_last_q  <= arr_last;
                out_valid_q <= 1'b1;
              end else begin
                skid_q      <= rx_dout_C;
                skid_last_q <= arr_last;
                skid_v_q    <= 1'b1;
              end
            end else if (consume) begin
              out_valid_q <= 1'b0;
            end
            if (consume & out_last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign get_rx_srq_C  = srq_q;
  assign get_buf_ctr_C = ctr_q;
  assign get_rx_samp_C = samp_q;
  assign reset_bufs_C  = rb_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign buf_ctr       = buf_ctr_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule
